// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizing helpers for the data-memory responder.
// The controller FSM encoding lives here so the bridge and the bench agree on it.
package dmem_pkg;

  // Controller state encoding (kept as plain constants for legacy tools)
  typedef logic [1:0] state_t;
  localparam state_t ST_LOAD = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DUMP = 2'd2;
  localparam state_t ST_HALT = 2'd3;

  // Word index width: byte address with the two sub-word bits dropped
  function automatic int idx_width(input int addr_width);
    return addr_width - 2;
  endfunction

  // Dump counter width: wide enough to also address an optional trailing beat
  function automatic int dump_cnt_width(input int dump_words);
    return (dump_words < 2) ? 1 : $clog2(dump_words + 1);
  endfunction

  localparam int DMEM_ADDR_WIDTH = 12;
  localparam int DMEM_IDX_WIDTH  = idx_width(DMEM_ADDR_WIDTH);
  localparam int DMEM_DUMP_WORDS = 16;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word-addressed storage with one synchronous write port and one
// combinational read port. The array is deliberately left unreset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int IDX_W      = DMEM_IDX_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Commit a store at the rising edge whenever the write port is enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory responder for the core's data port. Owns the RAM,
// hands it to the host in LOAD/HALT and to the core in RUN, and on ebreak
// streams words 0..DUMP_WORDS-1 out over a valid/ready dump channel.
// Optional build macro: DMEM_DUMP_CHECKSUM_EN appends one beat carrying the
// XOR of all dumped words, and dump_last_o moves onto that beat.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int DUMP_WORDS = DMEM_DUMP_WORDS
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  input  logic                  cpu_we_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                  ebreak_i,
  output logic                  cpu_hold_o,
  input  logic                  start_i,
  input  logic                  host_valid_i,
  output logic                  host_ready_o,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_rvalid_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  output logic                  dump_last_o,
  output logic                  halted_o
);

  localparam int IDX_W = idx_width(ADDR_WIDTH);
  localparam int CNT_W = dump_cnt_width(DUMP_WORDS);

`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DUMP_WORDS);
`else
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DUMP_WORDS - 1);
`endif

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]      dump_idx;
  logic [IDX_W-1:0]      cpu_word;
  logic [IDX_W-1:0]      host_word;
  logic                  host_fire;
  logic                  dump_fire;
  logic                  dump_end;
  logic                  ram_we;
  logic [IDX_W-1:0]      ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [IDX_W-1:0]      ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr_lsbs;

  assign cpu_word  = cpu_addr_i[ADDR_WIDTH-1:2];
  assign host_word = host_addr_i[ADDR_WIDTH-1:2];

  // Only whole-word accesses exist, so the byte-offset bits carry no meaning
  assign unused_addr_lsbs = ^{cpu_addr_i[1:0], host_addr_i[1:0]};

  assign cpu_hold_o   = (state != ST_RUN);
  assign host_ready_o = (state == ST_LOAD) || (state == ST_HALT);
  assign halted_o     = (state == ST_HALT);
  assign dump_valid_o = (state == ST_DUMP);
  assign dump_last_o  = dump_valid_o && (dump_idx == LAST_IDX);
  assign cpu_rdata_o  = (state == ST_RUN) ? ram_rdata : '0;

  assign host_fire = host_valid_i && host_ready_o;
  assign dump_fire = dump_valid_o && dump_ready_i;
  assign dump_end  = dump_fire && (dump_idx == LAST_IDX);

  // Next-state logic: start releases the core, ebreak freezes it, last beat halts
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD, ST_HALT: if (start_i)  state_nxt = ST_RUN;
      ST_RUN:           if (ebreak_i) state_nxt = ST_DUMP;
      ST_DUMP:          if (dump_end) state_nxt = ST_HALT;
      default:          state_nxt = ST_LOAD;
    endcase
  end

  // RAM arbitration: the state alone decides who owns both ports
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = host_word;
    ram_wdata = host_wdata_i;
    ram_raddr = host_word;
    case (state)
      ST_RUN: begin
        ram_we    = cpu_we_i;
        ram_waddr = cpu_word;
        ram_wdata = cpu_wdata_i;
        ram_raddr = cpu_word;
      end
      ST_DUMP: begin
        ram_raddr = IDX_W'(dump_idx);
      end
      default: begin
        ram_we = host_fire && host_we_i;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Dump index steps per handshake and wraps to zero after the final beat
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dump_idx <= '0;
    end else if (dump_fire) begin
      dump_idx <= dump_end ? '0 : dump_idx + CNT_W'(1);
    end
  end

  // Host reads capture the RAM word at the accepting edge and pulse rvalid once
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
    end else begin
      host_rvalid_o <= host_fire && !host_we_i;
      if (host_fire && !host_we_i) begin
        host_rdata_o <= ram_rdata;
      end
    end
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] dump_xor;

  // Running XOR of the words already sent, cleared as the dump begins
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dump_xor <= '0;
    end else if ((state == ST_RUN) && ebreak_i) begin
      dump_xor <= '0;
    end else if (dump_fire && (dump_idx != LAST_IDX)) begin
      dump_xor <= dump_xor ^ ram_rdata;
    end
  end

  assign dump_data_o = !dump_valid_o          ? '0       :
                       (dump_idx == LAST_IDX) ? dump_xor : ram_rdata;
`else
  assign dump_data_o = dump_valid_o ? ram_rdata : '0;
`endif

  dmem_ram #(
    .IDX_W      (IDX_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed sequence with randomized data/addresses, checked
// against a plain array model of the memory and the dump ordering rules.
module tb_dmem_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NW = 16;
  localparam int MW = 64;
`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam int NBEATS = NW + 1;
`else
  localparam int NBEATS = NW;
`endif

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic          cpu_we_i;
  logic [DW-1:0] cpu_rdata_o;
  logic          ebreak_i;
  logic          cpu_hold_o;
  logic          start_i;
  logic          host_valid_i;
  logic          host_ready_o;
  logic          host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_wdata_i;
  logic          host_rvalid_o;
  logic [DW-1:0] host_rdata_o;
  logic          dump_valid_o;
  logic          dump_ready_i;
  logic [DW-1:0] dump_data_o;
  logic          dump_last_o;
  logic          halted_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [MW];

  always #5 clk_i = ~clk_i;

  dmem_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DUMP_WORDS (NW)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_wdata_i   (cpu_wdata_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_rdata_o   (cpu_rdata_o),
    .ebreak_i      (ebreak_i),
    .cpu_hold_o    (cpu_hold_o),
    .start_i       (start_i),
    .host_valid_i  (host_valid_i),
    .host_ready_o  (host_ready_o),
    .host_we_i     (host_we_i),
    .host_addr_i   (host_addr_i),
    .host_wdata_i  (host_wdata_i),
    .host_rvalid_o (host_rvalid_o),
    .host_rdata_o  (host_rdata_o),
    .dump_valid_o  (dump_valid_o),
    .dump_ready_i  (dump_ready_i),
    .dump_data_o   (dump_data_o),
    .dump_last_o   (dump_last_o),
    .halted_o      (halted_o)
  );

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [AW-1:0] word_addr(input int w, input int lsb);
    logic [AW-1:0] a;
    a = AW'(w * 4 + lsb);
    return a;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input int b);
    logic [DW-1:0] x;
    if (b < NW) return model_mem[b];
    x = '0;
    for (int i = 0; i < NW; i++) x = x ^ model_mem[i];
    return x;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_hold"},   cpu_hold_o,    1'b1);
    check_bit({tag, "_ready"},  host_ready_o,  1'b1);
    check_bit({tag, "_rvalid"}, host_rvalid_o, 1'b0);
    check_word({tag, "_rdata"}, host_rdata_o,  '0);
    check_bit({tag, "_dvalid"}, dump_valid_o,  1'b0);
    check_bit({tag, "_dlast"},  dump_last_o,   1'b0);
    check_bit({tag, "_halted"}, halted_o,      1'b0);
    check_word({tag, "_cpu_rdata"}, cpu_rdata_o, '0);
  endtask

  task automatic host_write(input int w, input logic [DW-1:0] data);
    host_valid_i = 1'b1;
    host_we_i    = 1'b1;
    host_addr_i  = word_addr(w, $urandom_range(0, 3));
    host_wdata_i = data;
    tick();
    host_valid_i = 1'b0;
    host_we_i    = 1'b0;
    model_mem[w] = data;
  endtask

  task automatic host_read(input string tag, input int w);
    host_valid_i = 1'b1;
    host_we_i    = 1'b0;
    host_addr_i  = word_addr(w, $urandom_range(0, 3));
    tick();
    host_valid_i = 1'b0;
    #1;
    check_bit({tag, "_rvalid"}, host_rvalid_o, 1'b1);
    check_word({tag, "_rdata"}, host_rdata_o, model_mem[w]);
    check_bit({tag, "_hold"}, cpu_hold_o, 1'b1);
    tick();
    check_bit({tag, "_rvalid_drop"}, host_rvalid_o, 1'b0);
  endtask

  task automatic cpu_store(input int w, input logic [DW-1:0] data);
    cpu_addr_i  = word_addr(w, 0);
    cpu_wdata_i = data;
    cpu_we_i    = 1'b1;
    tick();
    cpu_we_i    = 1'b0;
    model_mem[w] = data;
  endtask

  // mode 0: ready pattern 1,0,0,1; mode 1: random ready; mode 2: always ready
  task automatic run_dump(input string tag, input int mode, input int reset_at);
    int   beat;
    int   cyc;
    logic rdy;
    logic [3:0] pat;
    beat = 0;
    cyc  = 0;
    pat  = 4'b1001;
    while (beat < NBEATS && cyc < 400) begin
      if (beat == reset_at) begin
        dump_ready_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs({tag, "_async_rst"});
        #1;
        rstn_i = 1'b1;
        return;
      end
      case (mode)
        0:       rdy = pat[cyc % 4];
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      dump_ready_i = rdy;
      #1;
      check_bit({tag, "_valid"}, dump_valid_o, 1'b1);
      check_word($sformatf("%s_data_b%0d", tag, beat), dump_data_o, exp_beat(beat));
      check_bit($sformatf("%s_last_b%0d", tag, beat), dump_last_o, beat == NBEATS - 1);
      check_bit({tag, "_hold"}, cpu_hold_o, 1'b1);
      if (rdy) beat++;
      tick();
      cyc++;
    end
    dump_ready_i = 1'b0;
    check_word({tag, "_beat_count"}, 32'(beat), 32'(NBEATS));
    check_bit({tag, "_valid_drop"}, dump_valid_o, 1'b0);
    check_bit({tag, "_halted"}, halted_o, 1'b1);
    check_bit({tag, "_hold_after"}, cpu_hold_o, 1'b1);
    check_bit({tag, "_ready_after"}, host_ready_o, 1'b1);
  endtask

  // Hard time limit so a stuck design can never hang the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence with randomized payloads
  initial begin
    rstn_i       = 1'b0;
    cpu_addr_i   = '0;
    cpu_wdata_i  = '0;
    cpu_we_i     = 1'b0;
    ebreak_i     = 1'b0;
    start_i      = 1'b0;
    host_valid_i = 1'b0;
    host_we_i    = 1'b0;
    host_addr_i  = '0;
    host_wdata_i = '0;
    dump_ready_i = 1'b0;

    #12;
    check_reset_outputs("reset");
    #11;
    rstn_i = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    $display("[TB] loading memory");
    for (int w = 0; w < MW; w++) host_write(w, $urandom());

    host_write(1, 32'hDEADBEEF);
    host_read("host_rd_deadbeef", 1);

    // back-to-back reads: one pulse per request
    host_valid_i = 1'b1;
    host_we_i    = 1'b0;
    host_addr_i  = word_addr(0, 0);
    tick();
    host_addr_i  = word_addr(1, 2);
    #1;
    check_bit("b2b_rvalid0", host_rvalid_o, 1'b1);
    check_word("b2b_rdata0", host_rdata_o, model_mem[0]);
    tick();
    host_valid_i = 1'b0;
    #1;
    check_bit("b2b_rvalid1", host_rvalid_o, 1'b1);
    check_word("b2b_rdata1", host_rdata_o, model_mem[1]);
    tick();
    check_bit("b2b_rvalid_drop", host_rvalid_o, 1'b0);

    // core port and ebreak are inert while the host owns memory
    cpu_addr_i  = word_addr(3, 0);
    cpu_wdata_i = 32'hFFFF0000;
    cpu_we_i    = 1'b1;
    ebreak_i    = 1'b1;
    tick();
    cpu_we_i    = 1'b0;
    ebreak_i    = 1'b0;
    check_word("load_cpu_rdata_zero", cpu_rdata_o, '0);
    check_bit("load_ebreak_ignored", dump_valid_o, 1'b0);
    host_read("load_cpu_we_ignored", 3);

    // release the core
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_bit("run_hold", cpu_hold_o, 1'b0);
    check_bit("run_host_ready", host_ready_o, 1'b0);

    cpu_store(2, 32'h12345678);
    cpu_addr_i = 12'h00A;
    #1;
    check_word("run_rd_0x00A", cpu_rdata_o, model_mem[2]);

    // host request in RUN must not touch memory
    host_valid_i = 1'b1;
    host_we_i    = 1'b1;
    host_addr_i  = word_addr(4, 0);
    host_wdata_i = 32'h0BAD0BAD;
    tick();
    host_valid_i = 1'b0;
    host_we_i    = 1'b0;
    check_bit("run_host_rvalid", host_rvalid_o, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int w;
      w = $urandom_range(0, MW - 1);
      cpu_store(w, $urandom());
      w = $urandom_range(0, MW - 1);
      cpu_addr_i = word_addr(w, $urandom_range(0, 3));
      #1;
      check_word($sformatf("run_rand_rd_w%0d", w), cpu_rdata_o, model_mem[w]);
    end

    // store and ebreak in the same cycle
    cpu_addr_i  = word_addr(0, 0);
    cpu_wdata_i = 32'hA5A5A5A5;
    cpu_we_i    = 1'b1;
    ebreak_i    = 1'b1;
    tick();
    cpu_we_i    = 1'b0;
    ebreak_i    = 1'b0;
    model_mem[0] = 32'hA5A5A5A5;
    start_i = 1'b1;
    run_dump("dump_bp", 0, -1);
    start_i = 1'b0;

    host_read("halt_rd", $urandom_range(0, MW - 1));

    // words 0..15 = 1..16; the last write coincides with start
    for (int w = 0; w < NW - 1; w++) host_write(w, DW'(w + 1));
    start_i = 1'b1;
    host_write(NW - 1, DW'(NW));
    start_i = 1'b0;
    check_bit("restart_halted_clr", halted_o, 1'b0);
    check_bit("restart_hold", cpu_hold_o, 1'b0);
    cpu_addr_i = word_addr(NW - 1, 0);
    #1;
    check_word("restart_write_landed", cpu_rdata_o, model_mem[NW - 1]);

    ebreak_i = 1'b1;
    tick();
    ebreak_i = 1'b0;
    run_dump("dump_rand", 1, -1);

    // third dump, interrupted by reset at beat 5
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ebreak_i = 1'b1;
    tick();
    ebreak_i = 1'b0;
    run_dump("dump_rst", 2, 5);
    tick();
    check_reset_outputs("after_dump_rst");
    for (int i = 0; i < 4; i++) host_read("post_rst_rd", $urandom_range(0, MW - 1));

    // reset while a host read result is pending
    host_valid_i = 1'b1;
    host_we_i    = 1'b0;
    host_addr_i  = word_addr(5, 0);
    tick();
    host_valid_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    check_bit("rst_pending_rvalid", host_rvalid_o, 1'b0);
    check_word("rst_pending_rdata", host_rdata_o, '0);
    #1;
    rstn_i = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory responder at the far end of the core's data port (address, write data, write enable in; read data out), with the core's ebreak fed back in. Owns a word-addressed RAM. Arbitrates between the core and a host load/inspect port. On ebreak it halts the core and streams a fixed window of memory out over a valid/ready dump channel. Sits beside the core in the top level; host and dump ports go to the testbench or debug bridge.

Parameters:
ADDR_WIDTH, 12, byte-address width of cpu/host address ports; RAM depth = 2^(ADDR_WIDTH-2) words
DATA_WIDTH, 32, word width
DUMP_WORDS, 16, words streamed after ebreak, starting at word 0; range 1..depth

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cpu_addr_i  in  ADDR_WIDTH  core data byte address
cpu_wdata_i  in  DATA_WIDTH  core store data
cpu_we_i  in  1  core store enable
cpu_rdata_o  out  DATA_WIDTH  core load data (combinational)
ebreak_i  in  1  core ebreak indication
cpu_hold_o  out  1  holds core in reset/stall when 1
start_i  in  1  host pulse: release core
host_valid_i  in  1  host request valid
host_ready_o  out  1  host request accepted when valid&ready
host_we_i  in  1  1=write, 0=read
host_addr_i  in  ADDR_WIDTH  host byte address
host_wdata_i  in  DATA_WIDTH  host write data
host_rvalid_o  out  1  host read data valid (1-cycle pulse)
host_rdata_o  out  DATA_WIDTH  host read data
dump_valid_o  out  1  dump beat valid
dump_ready_i  in  1  dump sink ready
dump_data_o  out  DATA_WIDTH  dump beat data
dump_last_o  out  1  final dump beat
halted_o  out  1  dump complete, core halted

Behaviour:
- Clock is clk_i. Reset is asynchronous and active-low on rstn_i.
- Reset values: state=LOAD, cpu_hold_o=1, host_ready_o=1, host_rvalid_o=0, host_rdata_o=0, dump_valid_o=0, dump_last_o=0, halted_o=0, dump index=0. RAM contents are not reset.
- Word index = addr[ADDR_WIDTH-1:2]. Low two address bits are ignored. Only whole-word accesses are supported.
- FSM states:
  - LOAD: host owns RAM; cpu_hold_o=1. Goes to RUN on start_i.
  - RUN: core owns RAM; cpu_hold_o=0; host_ready_o=0. Goes to DUMP on ebreak_i.
  - DUMP: streams window; cpu_hold_o=1. Goes to HALT on handshake of the last beat.
  - HALT: host owns RAM; halted_o=1; cpu_hold_o=1. Goes to RUN on start_i, which clears halted_o.
- start_i is ignored in RUN and DUMP. ebreak_i is ignored outside RUN.
- RUN:
  - cpu_rdata_o = RAM[cpu word] combinationally.
  - Store is written at the rising edge when cpu_we_i=1.
  - If cpu_we_i and ebreak_i are high in the same cycle, the store is committed and the FSM still enters DUMP.
- cpu_rdata_o=0 and cpu_we_i is ignored in all states other than RUN.
- Host port (LOAD/HALT only):
  - host_ready_o=1 in these states.
  - Write: commits at the accepting edge.
  - Read: host_rdata_o is registered at the accepting edge and host_rvalid_o=1 for the next cycle only. Back-to-back reads give one pulse per request.
  - A write followed by a read of the same address in the next cycle returns the new data.
  - If start_i and an accepted host request coincide, the request completes and the FSM enters RUN.
- DUMP:
  - dump_valid_o=1 for the whole state.
  - dump_data_o = RAM[dump index] and is stable while valid & !ready.
  - The index advances on valid&ready.
  - dump_last_o=1 when index = DUMP_WORDS-1.
  - On the last handshake: index resets to 0, valid drops and the FSM enters HALT.
- Single RAM read address mux: RUN selects the cpu word, DUMP selects the dump index, LOAD/HALT select the host word.
- Reset asserted mid-DUMP or mid-host-read: outputs return immediately to reset values and the FSM enters LOAD. A pending rvalid is lost.

Optional Feature:
- Macro DMEM_DUMP_CHECKSUM_EN.
- When defined:
  - A running XOR of all dumped words is accumulated and cleared on entry to DUMP.
  - One extra beat carrying that XOR follows word DUMP_WORDS-1.
  - dump_last_o moves to the checksum beat, so there are DUMP_WORDS+1 beats in total.
- When undefined: exactly DUMP_WORDS beats and no accumulator logic.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (LOAD, RUN, DUMP, HALT);
  - the word-index width localparam derived from ADDR_WIDTH;
  - the dump counter width.
- One sub-module, dmem_ram: single write port, single combinational read port, no reset on the array.
- The FSM, arbitration mux and dump counter stay in dmem_ctrl.

Test Plan:
- Reset, then host writes 0xDEADBEEF to 0x004 and reads 0x004 -> host_rvalid_o pulses one cycle after acceptance with 0xDEADBEEF; cpu_hold_o=1 throughout.
- start_i, core stores 0x12345678 to 0x008, then reads 0x00A -> cpu_rdata_o=0x12345678 (low bits ignored); host_ready_o=0 during RUN.
- In RUN: ebreak_i with cpu_we_i storing 0xA5A5A5A5 at 0x000 -> DUMP; first beat dump_data_o=0xA5A5A5A5; 16 beats total; dump_last_o only on beat 15; halted_o=1 after.
- Dump backpressure: dump_ready_i toggles 1,0,0,1 -> dump_data_o held stable while stalled, no beat skipped or repeated.
- rstn_i asserted at beat 5 of a dump -> all outputs return to reset values asynchronously; state LOAD; previously written RAM words still readable by host.
- With DMEM_DUMP_CHECKSUM_EN: words 0..15 = 1..16 -> 17 beats, beat 16 = 0x00000010 (XOR of 1..16), dump_last_o only on beat 16.
